// File: rtl/pipelined_sub16.sv
// Two-stage pipelined subtractor: result = operA - operB - Bin.
// Valid/ready handshake on both sides, with full-rate throughput.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   inValid    upstream offers operands
//   inReady    block can accept operands this cycle
//   operA      minuend
//   operB      subtrahend
//   Bin        borrow-in
//   outValid   result and flags valid
//   outReady   downstream takes the result this cycle
//   resultOUT  difference modulo 2^WIDTH
//   Bout       borrow-out (unsigned operA < operB + Bin)
//   Zout       result is zero
//   Nout       result MSB
//   Vout       signed overflow
module pipelined_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] operA,
    input  logic [WIDTH-1:0] operB,
    input  logic             Bin,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] resultOUT,
    output logic             Bout,
    output logic             Zout,
    output logic             Nout,
    output logic             Vout
);

    localparam int H = WIDTH / 2;

    // Stage 1 state: low half of the difference, mid carry,
    // and the untouched high halves of both operands.
    logic         v1_q;
    logic         v1_d;
    logic [H-1:0] lo_q;
    logic [H-1:0] lo_d;
    logic         cmid_q;
    logic         cmid_d;
    logic [H-1:0] ahi_q;
    logic [H-1:0] ahi_d;
    logic [H-1:0] bhi_q;
    logic [H-1:0] bhi_d;

    // Stage 2 state: complete result and flags.
    logic             v2_q;
    logic             v2_d;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             bout_q;
    logic             bout_d;
    logic             z_q;
    logic             z_d;
    logic             n_q;
    logic             n_d;
    logic             ovf_q;
    logic             ovf_d;

    logic         ld1;
    logic         ld2;
    logic         accept;
    logic [H:0]   lo_sum;
    logic [H:0]   hi_sum;

    // Handshake control.
    assign ld2     = ~v2_q | outReady;
    assign ld1     = ~v1_q | ld2;
    assign inReady = ~v1_q | ~v2_q | outReady;
    assign accept  = inValid & inReady;

    // Subtraction as A + ~B + ~Bin; carry out of the low half feeds
    // the high half one stage later.
    always_comb begin
        lo_sum = {1'b0, operA[H-1:0]}
               + {1'b0, ~operB[H-1:0]}
               + {{H{1'b0}}, ~Bin};
        lo_d   = lo_sum[H-1:0];
        cmid_d = lo_sum[H];
        ahi_d  = operA[WIDTH-1:H];
        bhi_d  = operB[WIDTH-1:H];
        v1_d   = accept;
    end

    always_comb begin
        hi_sum = {1'b0, ahi_q}
               + {1'b0, ~bhi_q}
               + {{H{1'b0}}, cmid_q};
        res_d  = {hi_sum[H-1:0], lo_q};
        // Carry out set means no borrow.
        bout_d = ~hi_sum[H];
        z_d    = (res_d == '0);
        n_d    = res_d[WIDTH-1];
        ovf_d  = (ahi_q[H-1] ^ bhi_q[H-1])
               & (res_d[WIDTH-1] ^ ahi_q[H-1]);
        v2_d   = v1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            lo_q   <= '0;
            cmid_q <= 1'b0;
            ahi_q  <= '0;
            bhi_q  <= '0;
        end else if (ld1) begin
            v1_q <= v1_d;
            // Operand fields only move on a real acceptance.
            if (accept) begin
                lo_q   <= lo_d;
                cmid_q <= cmid_d;
                ahi_q  <= ahi_d;
                bhi_q  <= bhi_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            res_q  <= '0;
            bout_q <= 1'b0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (ld2) begin
            v2_q <= v2_d;
            // A bubble leaves the last result in place.
            if (v1_q) begin
                res_q  <= res_d;
                bout_q <= bout_d;
                z_q    <= z_d;
                n_q    <= n_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign outValid  = v2_q;
    assign resultOUT = res_q;
    assign Bout      = bout_q;
    assign Zout      = z_q;
    assign Nout      = n_q;
    assign Vout      = ovf_q;

endmodule

// File: doc/pipelined_sub16.md
PIPELINED_SUB16 -- requirements
Module: pipelined_sub16

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; SHALL be even and >= 4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: inValid  input  1  upstream offers operands this cycle.
REQ-005 Port: inReady  output  1  block accepts operands this cycle.
REQ-006 Port: operA  input  WIDTH  minuend.
REQ-007 Port: operB  input  WIDTH  subtrahend.
REQ-008 Port: Bin  input  1  borrow-in; result is operA - operB - Bin.
REQ-009 Port: outValid  output  1  result/flags valid.
REQ-010 Port: outReady  input  1  downstream accepts result this cycle.
REQ-011 Port: resultOUT  output  WIDTH  difference modulo 2^WIDTH.
REQ-012 Port: Bout  output  1  borrow-out; 1 iff unsigned operA < operB + Bin.
REQ-013 Port: Zout  output  1  1 iff resultOUT == 0.
REQ-014 Port: Nout  output  1  resultOUT[WIDTH-1].
REQ-015 Port: Vout  output  1  signed overflow: operA/operB MSBs differ and result MSB differs from operA MSB.

Function
REQ-016 Computation SHALL be operA + ~operB + ~Bin, with Bout = inverted carry-out of bit WIDTH-1.
REQ-017 Stage 1 SHALL compute the low WIDTH/2 bits plus mid carry, and register them with operA/operB high halves and a valid bit v1.
REQ-018 Stage 2 SHALL compute the high WIDTH/2 bits from the registered mid carry, and register the full result, Bout, Zout, Nout, Vout, and valid bit v2.
REQ-019 outValid SHALL equal v2; all result/flag outputs SHALL come directly from stage-2 registers.
REQ-020 Transfer in SHALL occur when inValid & inReady; transfer out SHALL occur when outValid & outReady.
REQ-021 Latency SHALL be 2 cycles: operands accepted at edge k give outValid=1 after edge k+1 when not stalled.
REQ-022 Throughput SHALL be one transaction per cycle while outReady=1.
REQ-023 Stage 2 SHALL load when (~v2 | outReady); on load, v2 takes v1.
REQ-024 Stage 1 SHALL load when (~v1 | stage-2 load); on load, v1 takes inValid & inReady.
REQ-025 inReady SHALL equal ~v1 | ~v2 | outReady (combinational).
REQ-026 When outValid=1 and outReady=0, resultOUT and all flags SHALL hold stable until the transfer completes.
REQ-027 Transactions SHALL leave in acceptance order, with none lost or duplicated; up to 2 transactions are in flight.
REQ-028 With both stages full and outReady=0, inReady SHALL be 0, and operand changes SHALL not affect held state.
REQ-029 A simultaneous output transfer and input acceptance in one cycle SHALL both complete.
REQ-030 Stage registers SHALL not capture data when their load condition is false, whatever inValid or the operand values are.

Reset
REQ-031 rst_n=0 SHALL immediately clear v1, v2, resultOUT, Bout, Zout, Nout, Vout to 0, so outValid=0 and inReady=1.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight transactions; nothing from before reset is ever presented.
REQ-033 After rst_n rises, the first operands SHALL be acceptable on the first rising edge.

Verification
REQ-034 operA=0x0100, operB=0x0001, Bin=0, outReady=1 -> 2 cycles later resultOUT=0x00FF, Bout=0, Z=0, N=0, V=0 (mid-carry path exercised).
REQ-035 operA=0x0000, operB=0x0001, Bin=0 -> resultOUT=0xFFFF, Bout=1, N=1, V=0, Z=0.
REQ-036 operA=0x8000, operB=0x0001 -> resultOUT=0x7FFF, V=1, N=0, Bout=0; operA=0x1234, operB=0x1233, Bin=1 -> 0x0000, Z=1, Bout=0.
REQ-037 Back-to-back inputs 1-1, 5-2, 9-3 with outReady held 0 for 4 cycles -> inReady falls after 2 accepted, 0x0000 held stable; then outReady=1 -> 0x0000, 0x0003, 0x0006 in order, one per cycle.
REQ-038 Two transactions in flight, rst_n pulsed low for 1 cycle -> outValid=0 at once, all outputs 0, no stale result after release; next input 3-1 -> 0x0002.
REQ-039 Random back-pressure over 10k random operand/Bin sets -> every output matches reference subtraction and flag model, in order, none dropped.
